mem2nfifo_flow: RTL and testbench

- Multi-flow buffer with one write port and FLOWS independent first-word-fall-through (FWFT) read ports.
- Backed by one shared memory split into FLOWS equal blocks of BLOCK_SIZE words, one block per flow.
- Successor to the fixed mem2nfifo. Adds per-flow flush, occupancy status, a programmable almost-full flag, and a small per-flow output prefetch buffer, so any single flow reads at full rate through one shared memory read port.

---
 rtl/mem2nfifo_flow.sv | 240 ++++++++++++++++++++++++
 tb/tb_mem2nfifo_flow.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem2nfifo_flow.sv
`default_nettype none
// ============================================================================
// Module   : mem2nfifo_flow
// Purpose  : Multi-flow buffer. One write port feeds a shared memory that is
//            split into FLOWS equal blocks. Each flow drains through its own
//            first-word-fall-through read port. A 3-entry prefetch FIFO per
//            flow lets any single flow read at full rate through the one
//            shared memory read port.
// Ports    : CLK, RESET          clock, async active-high reset
//            DATA_IN/BLOCK_ADDR/WRITE   write data, target flow, strobe
//            FULL/ALMOST_FULL    per-flow registered memory flags
//            STATUS              per-flow memory occupancy (slice per flow)
//            FLUSH               per-flow synchronous clear
//            DATA_OUT/DATA_VLD   per-flow head word and its valid
//            READ                per-flow pop (ignored without DATA_VLD)
//            EMPTY               flow holds no data anywhere
// Revision : 1.0 - initial release
// ============================================================================
module mem2nfifo_flow #(
  parameter int DATA_WIDTH = 64,
  parameter int FLOWS      = 8,
  parameter int BLOCK_SIZE = 512,
  parameter int LUT_MEMORY = 0,
  parameter int AF_OFFSET  = 4
) (
  input  logic                                     CLK,
  input  logic                                     RESET,
  input  logic [DATA_WIDTH-1:0]                    DATA_IN,
  input  logic [$clog2(FLOWS)-1:0]                 BLOCK_ADDR,
  input  logic                                     WRITE,
  output logic [FLOWS-1:0]                         FULL,
  output logic [FLOWS-1:0]                         ALMOST_FULL,
  output logic [FLOWS*($clog2(BLOCK_SIZE)+1)-1:0]  STATUS,
  input  logic [FLOWS-1:0]                         FLUSH,
  output logic [FLOWS*DATA_WIDTH-1:0]              DATA_OUT,
  output logic [FLOWS-1:0]                         DATA_VLD,
  input  logic [FLOWS-1:0]                         READ,
  output logic [FLOWS-1:0]                         EMPTY
);

  localparam int c_FW       = $clog2(FLOWS);
  localparam int c_AW       = $clog2(BLOCK_SIZE);
  localparam int c_PW       = c_AW + 1;
  localparam int c_DEPTH    = FLOWS * BLOCK_SIZE;
  localparam int c_OB_DEPTH = 3;
  localparam int c_AF_LEVEL = BLOCK_SIZE - AF_OFFSET;

  // Per-flow pointer state
  logic [c_PW-1:0]       r_wr_ptr  [FLOWS];
  logic [c_PW-1:0]       r_rd_ptr  [FLOWS];
  logic [c_PW-1:0]       w_wr_nxt  [FLOWS];
  logic [c_PW-1:0]       w_rd_nxt  [FLOWS];
  logic [c_PW-1:0]       w_occ     [FLOWS];
  logic [c_PW-1:0]       w_occ_nxt [FLOWS];
  logic [FLOWS-1:0]      r_full;
  logic [FLOWS-1:0]      r_afull;

  // Per-flow output prefetch FIFO (entry 0 is always the head)
  logic [1:0]            r_ob_cnt  [FLOWS];
  logic [1:0]            w_ob_post [FLOWS];
  logic [DATA_WIDTH-1:0] r_ob_data [FLOWS][c_OB_DEPTH];

  logic [FLOWS-1:0]      w_pop;
  logic [FLOWS-1:0]      w_push;
  logic [FLOWS-1:0]      w_elig;
  logic [FLOWS-1:0]      w_inflight;

  // Shared memory and read pipeline
  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic                  w_wr_en;
  logic [c_FW+c_AW-1:0]  w_wr_addr;
  logic [c_FW+c_AW-1:0]  w_rd_addr;
  logic                  w_gnt_vld;
  logic [c_FW-1:0]       w_gnt_flow;
  logic [c_FW-1:0]       w_rr_idx;
  logic [c_FW-1:0]       r_last;
  logic                  r_s1_vld;
  logic [c_FW-1:0]       r_s1_flow;
  logic [DATA_WIDTH-1:0] r_rdata;

  // --------------------------------------------------------------------------
  // Write side: a flush of the target flow wins over the write.
  // --------------------------------------------------------------------------
  assign w_wr_en   = WRITE && !r_full[BLOCK_ADDR] && !FLUSH[BLOCK_ADDR];
  assign w_wr_addr = {BLOCK_ADDR, r_wr_ptr[BLOCK_ADDR][c_AW-1:0]};

  // --------------------------------------------------------------------------
  // Per-flow occupancy, FIFO handshakes and read eligibility.
  // Only one read is ever in flight (a single pipeline stage), so the
  // in-flight count per flow is 0 or 1.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int f = 0; f < FLOWS; f++) begin
      w_occ[f]      = r_wr_ptr[f] - r_rd_ptr[f];
      w_inflight[f] = r_s1_vld && (r_s1_flow == c_FW'(f));
      w_pop[f]      = READ[f] && (r_ob_cnt[f] != 2'd0) && !FLUSH[f];
      // A flush arriving while the read is in flight discards its data.
      w_push[f]     = w_inflight[f] && !FLUSH[f];
      w_ob_post[f]  = r_ob_cnt[f] - 2'(w_pop[f]);
      // Reserve a FIFO slot for the returning word before issuing a read.
      w_elig[f]     = (w_occ[f] != '0) && !FLUSH[f] &&
                      ((3'(w_ob_post[f]) + 3'(w_inflight[f])) < 3'(c_OB_DEPTH));
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin arbiter: search starts at the flow after the last grant.
  // --------------------------------------------------------------------------
  always_comb begin
    w_gnt_vld  = 1'b0;
    w_gnt_flow = r_last;
    w_rr_idx   = r_last;
    for (int i = 1; i <= FLOWS; i++) begin
      w_rr_idx = r_last + c_FW'(i);
      if (!w_gnt_vld && w_elig[w_rr_idx]) begin
        w_gnt_vld  = 1'b1;
        w_gnt_flow = w_rr_idx;
      end
    end
  end

  assign w_rd_addr = {w_gnt_flow, r_rd_ptr[w_gnt_flow][c_AW-1:0]};

  // Next pointers; flags are registered from the next occupancy so they
  // always agree with STATUS in the same cycle.
  always_comb begin
    for (int f = 0; f < FLOWS; f++) begin
      w_wr_nxt[f] = r_wr_ptr[f] + c_PW'(w_wr_en && (BLOCK_ADDR == c_FW'(f)));
      w_rd_nxt[f] = r_rd_ptr[f] + c_PW'(w_gnt_vld && (w_gnt_flow == c_FW'(f)));
      if (FLUSH[f]) begin
        w_wr_nxt[f] = '0;
        w_rd_nxt[f] = '0;
      end
      w_occ_nxt[f] = w_wr_nxt[f] - w_rd_nxt[f];
    end
  end

  // --------------------------------------------------------------------------
  // Per-flow state registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_full  <= '0;
      r_afull <= '0;
      for (int f = 0; f < FLOWS; f++) begin
        r_wr_ptr[f] <= '0;
        r_rd_ptr[f] <= '0;
        r_ob_cnt[f] <= '0;
        for (int e = 0; e < c_OB_DEPTH; e++) begin
          r_ob_data[f][e] <= '0;
        end
      end
    end else begin
      for (int f = 0; f < FLOWS; f++) begin
        r_wr_ptr[f] <= w_wr_nxt[f];
        r_rd_ptr[f] <= w_rd_nxt[f];
        r_full[f]   <= (w_occ_nxt[f] == c_PW'(BLOCK_SIZE));
        r_afull[f]  <= (w_occ_nxt[f] >= c_PW'(c_AF_LEVEL));
        if (FLUSH[f]) begin
          r_ob_cnt[f] <= '0;
        end else begin
          r_ob_cnt[f] <= w_ob_post[f] + 2'(w_push[f]);
        end
        if (w_pop[f]) begin
          r_ob_data[f][0] <= r_ob_data[f][1];
          r_ob_data[f][1] <= r_ob_data[f][2];
        end
        // The returning word lands just behind whatever survives the pop.
        for (int e = 0; e < c_OB_DEPTH; e++) begin
          if (w_push[f] && (w_ob_post[f] == 2'(e))) begin
            r_ob_data[f][e] <= r_rdata;
          end
        end
      end
    end
  end

  // Read pipeline tracking; r_last starts at the top flow so flow 0 has
  // first priority after reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_s1_vld  <= 1'b0;
      r_s1_flow <= '0;
      r_last    <= '1;
    end else begin
      r_s1_vld <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_s1_flow <= w_gnt_flow;
        r_last    <= w_gnt_flow;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Shared memory. A word written at an edge is only read from the next
  // cycle on, so no read/write collision handling is needed.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= DATA_IN;
    end
  end

  generate
    if (LUT_MEMORY != 0) begin : g_lut_mem
      // Asynchronous read followed by an output register keeps the same
      // one-cycle read latency as the block RAM variant.
      logic [DATA_WIDTH-1:0] w_lut_q;
      assign w_lut_q = r_mem[w_rd_addr];
      always_ff @(posedge CLK) begin
        if (w_gnt_vld) begin
          r_rdata <= w_lut_q;
        end
      end
    end else begin : g_bram_mem
      always_ff @(posedge CLK) begin
        if (w_gnt_vld) begin
          r_rdata <= r_mem[w_rd_addr];
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign FULL        = r_full;
  assign ALMOST_FULL = r_afull;

  generate
    for (genvar g = 0; g < FLOWS; g++) begin : g_out
      assign STATUS[g*c_PW +: c_PW]               = w_occ[g];
      assign DATA_OUT[g*DATA_WIDTH +: DATA_WIDTH] = r_ob_data[g][0];
      assign DATA_VLD[g]                          = (r_ob_cnt[g] != 2'd0);
      assign EMPTY[g] = (w_occ[g] == '0) && (r_ob_cnt[g] == 2'd0) && !w_inflight[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mem2nfifo_flow.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem2nfifo_flow
// Purpose  : Self-checking bench for mem2nfifo_flow (4 flows x 16 words).
//            Each flow is modelled as a plain queue of every word it holds;
//            data order, emptiness and STATUS bounds are checked every cycle,
//            with directed steps for latency, flags, fairness, flush, reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem2nfifo_flow;

  localparam int DW = 16;
  localparam int FL = 4;
  localparam int BS = 16;
  localparam int PW = 5;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [DW-1:0]     DATA_IN;
  logic [1:0]        BLOCK_ADDR;
  logic              WRITE;
  logic [FL-1:0]     FULL;
  logic [FL-1:0]     ALMOST_FULL;
  logic [FL*PW-1:0]  STATUS;
  logic [FL-1:0]     FLUSH;
  logic [FL*DW-1:0]  DATA_OUT;
  logic [FL-1:0]     DATA_VLD;
  logic [FL-1:0]     READ;
  logic [FL-1:0]     EMPTY;

  mem2nfifo_flow #(
    .DATA_WIDTH (DW),
    .FLOWS      (FL),
    .BLOCK_SIZE (BS),
    .LUT_MEMORY (0),
    .AF_OFFSET  (4)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .DATA_IN     (DATA_IN),
    .BLOCK_ADDR  (BLOCK_ADDR),
    .WRITE       (WRITE),
    .FULL        (FULL),
    .ALMOST_FULL (ALMOST_FULL),
    .STATUS      (STATUS),
    .FLUSH       (FLUSH),
    .DATA_OUT    (DATA_OUT),
    .DATA_VLD    (DATA_VLD),
    .READ        (READ),
    .EMPTY       (EMPTY)
  );

  always #5 CLK = ~CLK;

  // Reference model: every word a flow currently holds, oldest first.
  logic [DW-1:0] q [FL][$];
  int delivered [FL];
  int first_vld [FL];
  int run       [FL];
  int max_run   [FL];
  int cyc;
  int checks;
  int failures;
  bit expect_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    for (int f = 0; f < FL; f++) begin
      delivered[f] = 0;
      first_vld[f] = -1;
      run[f]       = 0;
      max_run[f]   = 0;
    end
  endtask

  function automatic logic [PW-1:0] st_of(input int f);
    return STATUS[f*PW +: PW];
  endfunction

  // Check the current cycle, apply this cycle's events to the model, and
  // advance to 1 time unit after the next rising edge.
  task automatic step();
    logic [PW-1:0] st;
    int sz;
    for (int f = 0; f < FL; f++) begin
      st = st_of(f);
      sz = q[f].size();
      chk("full_rule", 32'(FULL[f]), 32'(st == 5'd16));
      chk("afull_rule", 32'(ALMOST_FULL[f]), 32'(st >= 5'd12));
      if (sz == 0) begin
        chk("empty_idle", 32'(EMPTY[f]), 32'd1);
        chk("vld_idle", 32'(DATA_VLD[f]), 32'd0);
        chk("status_idle", 32'(st), 32'd0);
      end else begin
        chk("empty_busy", 32'(EMPTY[f]), 32'd0);
        chk("status_bound", 32'((int'(st) <= sz) && (int'(st) + 4 >= sz)), 32'd1);
        if (DATA_VLD[f] === 1'b1) chk("head_data", 32'(DATA_OUT[f*DW +: DW]), 32'(q[f][0]));
      end
      if (DATA_VLD[f] === 1'b1) begin
        if (first_vld[f] < 0) first_vld[f] = cyc;
        run[f]++;
        if (run[f] > max_run[f]) max_run[f] = run[f];
      end else begin
        run[f] = 0;
      end
    end
    for (int f = 0; f < FL; f++) begin
      if (FLUSH[f]) begin
        q[f].delete();
      end else if (READ[f] && (DATA_VLD[f] === 1'b1) && (q[f].size() > 0)) begin
        void'(q[f].pop_front());
        delivered[f]++;
      end
    end
    if (WRITE && !FLUSH[BLOCK_ADDR] && !expect_drop) q[BLOCK_ADDR].push_back(DATA_IN);
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic wr(input int fl, input logic [DW-1:0] d);
    WRITE      = 1'b1;
    BLOCK_ADDR = 2'(fl);
    DATA_IN    = d;
    step();
    WRITE      = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int mx;
    int mn;
    checks = 0; failures = 0; cyc = 0; expect_drop = 1'b0;
    RESET = 1'b1; WRITE = 1'b0; BLOCK_ADDR = '0; DATA_IN = '0; FLUSH = '0; READ = '0;
    clear_obs();
    @(posedge CLK);
    #1;
    // ---- reset state
    chk("rst_full", 32'(FULL), 32'd0);
    chk("rst_afull", 32'(ALMOST_FULL), 32'd0);
    chk("rst_status", 32'(STATUS), 32'd0);
    chk("rst_vld", 32'(DATA_VLD), 32'd0);
    chk("rst_empty", 32'(EMPTY), 32'hF);
    chk("rst_dout", 32'(DATA_OUT === '0), 32'd1);
    RESET = 1'b0;
    step();

    // ---- basic latency and order: A1..A5 to flow 2
    clear_obs();
    READ = 4'b0100;
    w0 = cyc;
    for (int k = 0; k < 5; k++) wr(2, 16'(16'hA1 + k));
    repeat (8) step();
    chk("lat_first_vld", 32'(first_vld[2] - w0), 32'd3);
    chk("lat_count", 32'(delivered[2]), 32'd5);
    chk("lat_empty_all", 32'(EMPTY), 32'hF);
    chk("lat_others_quiet", 32'((first_vld[0] < 0) && (first_vld[1] < 0) && (first_vld[3] < 0)), 32'd1);
    READ = '0;

    // ---- full / almost-full on flow 1
    clear_obs();
    for (int k = 0; k < 14; k++) wr(1, 16'(16'h100 + k));
    repeat (3) step();
    chk("af_st11", 32'(st_of(1)), 32'd11);
    chk("af_at11", 32'(ALMOST_FULL[1]), 32'd0);
    wr(1, 16'h10E);
    repeat (3) step();
    chk("af_st12", 32'(st_of(1)), 32'd12);
    chk("af_at12", 32'(ALMOST_FULL[1]), 32'd1);
    wr(1, 16'h10F);
    repeat (3) step();
    chk("st13", 32'(st_of(1)), 32'd13);
    chk("full_at13", 32'(FULL[1]), 32'd0);
    for (int k = 0; k < 3; k++) wr(1, 16'(16'h110 + k));
    repeat (3) step();
    chk("st16", 32'(st_of(1)), 32'd16);
    chk("full_at16", 32'(FULL[1]), 32'd1);
    expect_drop = 1'b1;
    wr(1, 16'h00FF);
    expect_drop = 1'b0;
    step();
    chk("drop_st16", 32'(st_of(1)), 32'd16);
    READ = 4'b0010;
    repeat (30) step();
    chk("drain19", 32'(delivered[1]), 32'd19);
    chk("drain_empty", 32'(EMPTY[1]), 32'd1);
    READ = '0;

    // ---- full rate on flow 0
    clear_obs();
    READ = 4'b0001;
    for (int k = 0; k < 32; k++) wr(0, 16'($urandom));
    repeat (8) step();
    chk("rate_run", 32'(max_run[0]), 32'd32);
    chk("rate_count", 32'(delivered[0]), 32'd32);
    READ = '0;

    // ---- round-robin fairness: 8 words in each flow, then all read
    for (int k = 0; k < 32; k++) wr(k % 4, 16'($urandom));
    repeat (4) step();
    clear_obs();
    READ = 4'hF;
    for (int c = 0; c < 30; c++) begin
      step();
      mx = delivered[0]; mn = delivered[0];
      for (int f = 1; f < FL; f++) begin
        if (delivered[f] > mx) mx = delivered[f];
        if (delivered[f] < mn) mn = delivered[f];
      end
      chk("rr_balance", 32'((mx - mn) <= 1), 32'd1);
    end
    for (int f = 0; f < FL; f++) chk("rr_count", 32'(delivered[f]), 32'd8);
    READ = '0;

    // ---- flush with a read in flight and a same-cycle write
    for (int k = 0; k < 10; k++) wr(3, 16'(16'h300 + k));
    for (int k = 0; k < 5; k++) wr(2, 16'(16'h200 + k));
    repeat (4) step();
    clear_obs();
    READ = 4'b1000;
    step();
    READ = '0;
    FLUSH = 4'b1000;
    WRITE = 1'b1; BLOCK_ADDR = 2'd3; DATA_IN = 16'h00EE;
    step();
    FLUSH = '0; WRITE = 1'b0;
    chk("fl_empty", 32'(EMPTY[3]), 32'd1);
    chk("fl_vld", 32'(DATA_VLD[3]), 32'd0);
    chk("fl_status", 32'(st_of(3)), 32'd0);
    repeat (4) step();
    chk("fl_still_empty", 32'(EMPTY[3]), 32'd1);
    READ = 4'b0100;
    repeat (10) step();
    chk("fl_flow2_intact", 32'(delivered[2]), 32'd5);
    READ = '0;

    // ---- randomized traffic against the queue model
    for (int c = 0; c < 300; c++) begin
      BLOCK_ADDR = 2'($urandom_range(0, 3));
      DATA_IN    = 16'($urandom);
      WRITE      = ($urandom_range(0, 1) == 1) && (q[BLOCK_ADDR].size() < BS);
      READ       = 4'($urandom);
      FLUSH      = ($urandom_range(0, 39) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      step();
    end
    WRITE = 1'b0; FLUSH = '0; READ = 4'hF;
    repeat (80) step();
    chk("rand_empty", 32'(EMPTY), 32'hF);
    for (int f = 0; f < FL; f++) chk("rand_model_drained", 32'(q[f].size()), 32'd0);

    // ---- asynchronous reset mid-operation
    READ = 4'hF;
    for (int k = 0; k < 5; k++) wr(1, 16'(16'h500 + k));
    WRITE = 1'b0; READ = '0;
    #3 RESET = 1'b1;
    #1;
    chk("arst_status", 32'(STATUS), 32'd0);
    chk("arst_vld", 32'(DATA_VLD), 32'd0);
    chk("arst_empty", 32'(EMPTY), 32'hF);
    chk("arst_flags", 32'({FULL, ALMOST_FULL}), 32'd0);
    chk("arst_dout", 32'(DATA_OUT === '0), 32'd1);
    for (int f = 0; f < FL; f++) q[f].delete();
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    clear_obs();
    READ = 4'b0010;
    w0 = cyc;
    wr(1, 16'h0777);
    repeat (5) step();
    chk("arst_lat", 32'(first_vld[1] - w0), 32'd3);
    chk("arst_count", 32'(delivered[1]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
